i2s_audio_tx: RTL and testbench

//  Serialises 16-bit stereo PCM from the TGFX16 shared core onto the Calypso board's
//  I2S DAC pins (I2S_BCK/I2S_LRCK/I2S_DATA). Sits directly downstream of the core audio mixer.

---
 rtl/tgfx16_audio_pkg.sv | 22 ++
 rtl/i2s_bclk_gen.sv | 44 ++++
 rtl/i2s_audio_tx.sv | 133 +++++++++++++
 tb/tb_i2s_audio_tx.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tgfx16_audio_pkg.sv
// Shared types and defaults for the TGFX16 audio output path.
package tgfx16_audio_pkg;

  localparam int unsigned DEF_BCK_DIV   = 4;
  localparam int unsigned DEF_SAMPLE_W  = 16;
  localparam int unsigned DEF_SLOT_BITS = 32;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } i2s_state_t;

  typedef struct packed {
    logic signed [15:0] l;
    logic signed [15:0] r;
  } stereo_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/i2s_bclk_gen.sv
// Bit-clock generator: divider, BCK, falling-edge event strobe and frame bit index.
module i2s_bclk_gen
  import tgfx16_audio_pkg::*;
#(
  parameter int unsigned BCK_DIV    = DEF_BCK_DIV,
  parameter int unsigned FRAME_BITS = 2 * DEF_SLOT_BITS
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          run,
  output logic                          bck,
  output logic                          ev,
  output logic [$clog2(FRAME_BITS)-1:0] b
);

  localparam int unsigned DW = (BCK_DIV > 1) ? $clog2(BCK_DIV) : 1;
  localparam int unsigned BW = $clog2(FRAME_BITS);
  localparam logic [DW-1:0] DIV_LAST = DW'(BCK_DIV - 1);
  localparam logic [BW-1:0] B_LAST   = BW'(FRAME_BITS - 1);

  logic [DW-1:0] div;
  logic          tc;

  assign tc = (div == DIV_LAST);
  // The event is the clk cycle on which bck is about to fall.
  assign ev = run && tc && bck;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div <= '0;
      bck <= 1'b0;
      b   <= '0;
    end else if (!run) begin
      div <= '0;
      bck <= 1'b0;
      b   <= '0;
    end else begin
      div <= tc ? '0 : div + DW'(1);
      if (tc) bck <= ~bck;
      if (ev) b <= (b == B_LAST) ? '0 : b + BW'(1);
    end
  end

endmodule

// File: rtl/i2s_audio_tx.sv
// I2S stereo serialiser with one-pair holding register and underrun counter.
// Define I2S_TX_LEFT_JUSTIFIED_EN for left-justified output instead of standard I2S.
module i2s_audio_tx
  import tgfx16_audio_pkg::*;
#(
  parameter int unsigned BCK_DIV   = DEF_BCK_DIV,
  parameter int unsigned SAMPLE_W  = DEF_SAMPLE_W,
  parameter int unsigned SLOT_BITS = DEF_SLOT_BITS
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                en,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [SAMPLE_W-1:0] s_left,
  input  logic [SAMPLE_W-1:0] s_right,
  output logic                i2s_bck,
  output logic                i2s_lrck,
  output logic                i2s_data,
  output logic [7:0]          underrun_cnt
);

  localparam int unsigned FRAME_BITS = 2 * SLOT_BITS;
  localparam int unsigned BW = $clog2(FRAME_BITS);
  localparam logic [BW-1:0] B_LAST = BW'(FRAME_BITS - 1);
  localparam logic [BW-1:0] B_SLOT = BW'(SLOT_BITS);

  i2s_state_t          state, state_next;
  logic [SAMPLE_W-1:0] hold_l, hold_r, cur_l, cur_r, new_l, new_r;
  logic                hold_full;
  logic                ev, frame_end, load, accept, data_upd;
  logic [BW-1:0]       b, b_next, b_upd;

  // Bit of frame word {L,pad,R,pad} at index idx, MSB of L at index 0.
  function automatic logic frame_bit(input logic [SAMPLE_W-1:0] l,
                                     input logic [SAMPLE_W-1:0] r,
                                     input logic [BW-1:0]       idx);
    logic [SAMPLE_W-1:0] sh;
    logic [BW-1:0]       pos;
    pos = (idx >= B_SLOT) ? idx - B_SLOT : idx;
    sh  = ((idx >= B_SLOT) ? r : l) << pos;
    return sh[SAMPLE_W-1];
  endfunction

  i2s_bclk_gen #(
    .BCK_DIV    (BCK_DIV),
    .FRAME_BITS (FRAME_BITS)
  ) u_bclk (
    .clk     (clk),
    .reset_n (reset_n),
    .run     (state == RUN),
    .bck     (i2s_bck),
    .ev      (ev),
    .b       (b)
  );

  assign frame_end = ev && (b == B_LAST);
  assign accept    = s_valid && !hold_full;
  assign s_ready   = ~hold_full;

  always_comb begin
    state_next = state;
    load       = 1'b0;
    case (state)
      IDLE: begin
        if (en) begin
          state_next = RUN;
          load       = 1'b1;
        end
      end
      RUN: begin
        if (frame_end) begin
          if (en) load = 1'b1;
          else    state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    new_l  = hold_full ? hold_l : cur_l;
    new_r  = hold_full ? hold_r : cur_r;
    b_next = (b == B_LAST) ? '0 : b + BW'(1);
    b_upd  = load ? '0 : b_next;
`ifdef I2S_TX_LEFT_JUSTIFIED_EN
    data_upd = load ? frame_bit(new_l, new_r, '0) : frame_bit(cur_l, cur_r, b_next);
`else
    // New index is b+1, so the bit due is frame bit b of the pair still playing.
    data_upd = frame_bit(cur_l, cur_r, (state == RUN) ? b : B_LAST);
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_l       <= '0;
      hold_r       <= '0;
      hold_full    <= 1'b0;
      cur_l        <= '0;
      cur_r        <= '0;
      i2s_lrck     <= 1'b0;
      i2s_data     <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      if (accept) begin
        hold_l    <= s_left;
        hold_r    <= s_right;
        hold_full <= 1'b1;
      end else if (load && hold_full) begin
        hold_full <= 1'b0;
      end
      if (load) begin
        cur_l <= new_l;
        cur_r <= new_r;
      end
      if (load && !hold_full && state == RUN)
        underrun_cnt <= sat_inc8(underrun_cnt);
      if (state_next == IDLE) begin
        i2s_lrck <= 1'b0;
        i2s_data <= 1'b0;
      end else if (load || ev) begin
        i2s_lrck <= (b_upd >= B_SLOT);
        i2s_data <= data_upd;
      end
    end
  end

endmodule

// File: tb/tb_i2s_audio_tx.sv
// Self-checking bench for i2s_audio_tx: frame-level reference model plus directed corner cases.
module tb_i2s_audio_tx;

  localparam int unsigned BD = 4;
  localparam int unsigned SB = 32;
  localparam int unsigned FR = 2 * SB * 2 * BD;
`ifdef I2S_TX_LEFT_JUSTIFIED_EN
  localparam int unsigned REP_B = 3;
`else
  localparam int unsigned REP_B = 4;
`endif

  typedef struct packed { logic [15:0] l; logic [15:0] r; } pair_t;
  typedef struct { int unsigned b; bit lrck; bit data; } vec_t;

  logic clk;
  logic reset_n, en, s_valid, s_ready, i2s_bck, i2s_lrck, i2s_data;
  logic [15:0] s_left, s_right;
  logic [7:0]  underrun_cnt;
  logic reset2_n, en2, valid2, ready2, bck2, lrck2, data2;
  logic [7:0] left2, right2, cnt2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  i2s_audio_tx #(.BCK_DIV(4), .SAMPLE_W(16), .SLOT_BITS(32)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .s_valid(s_valid), .s_ready(s_ready),
    .s_left(s_left), .s_right(s_right), .i2s_bck(i2s_bck), .i2s_lrck(i2s_lrck),
    .i2s_data(i2s_data), .underrun_cnt(underrun_cnt));

  // Small-frame instance (64 clk per frame) for long frame-count scenarios.
  i2s_audio_tx #(.BCK_DIV(2), .SAMPLE_W(8), .SLOT_BITS(8)) dut2 (
    .clk(clk), .reset_n(reset2_n), .en(en2), .s_valid(valid2), .s_ready(ready2),
    .s_left(left2), .s_right(right2), .i2s_bck(bck2), .i2s_lrck(lrck2),
    .i2s_data(data2), .underrun_cnt(cnt2));

  int unsigned n_chk, n_fail, n;
  bit          m_run, m_full;
  int unsigned m_t, m_cnt;
  pair_t       m_cur, m_prev, m_hold;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit fbit(input pair_t p, input int unsigned idx);
    logic [63:0] w;
    w = {p.l, 16'h0000, p.r, 16'h0000};
    return w[6'(63 - idx)];
  endfunction

  task automatic model_load(input bit count);
    m_prev = m_cur;
    if (m_full) begin
      m_cur  = m_hold;
      m_full = 1'b0;
    end else if (count && m_cnt < 255) begin
      m_cnt++;
    end
  endtask

  task automatic model_step();
    bit acc;
    if (!reset_n) begin
      m_run = 0; m_full = 0; m_t = 0; m_cnt = 0; m_cur = '0; m_prev = '0; m_hold = '0;
      return;
    end
    acc = s_valid && !m_full;
    if (!m_run) begin
      if (en) begin m_run = 1; m_t = 0; model_load(1'b0); end
    end else begin
      m_t++;
      if (m_t == FR) begin
        m_t = 0;
        if (en) model_load(1'b1);
        else    m_run = 0;
      end
    end
    if (acc) begin m_hold = {s_left, s_right}; m_full = 1'b1; end
  endtask

  task automatic model_compare();
    int unsigned mb;
    bit eb, el, ed;
    eb = 0; el = 0; ed = 0;
    if (m_run) begin
      mb = m_t / (2 * BD);
      eb = (m_t % (2 * BD)) >= BD;
      el = mb >= SB;
`ifdef I2S_TX_LEFT_JUSTIFIED_EN
      ed = fbit(m_cur, mb);
`else
      ed = (mb == 0) ? fbit(m_prev, 63) : fbit(m_cur, mb - 1);
`endif
    end
    check("model_bck", i2s_bck, eb);
    check("model_lrck", i2s_lrck, el);
    check("model_data", i2s_data, ed);
    check("model_s_ready", s_ready, !m_full);
    check("model_underrun_cnt", underrun_cnt, m_cnt);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
    model_compare();
  endtask

  task automatic run_to(input int unsigned target);
    while (n < target) begin tick(); n++; end
  endtask

  task automatic measure(input bit use_lrck, input int unsigned limit,
                         input int unsigned exp, input string name);
    logic prev, cur;
    int unsigned r1, r2, k;
    bit got1;
    r1 = 0; r2 = 0; k = 0; got1 = 0;
    prev = use_lrck ? i2s_lrck : i2s_bck;
    while (k < limit && r2 == 0) begin
      tick(); n++; k++;
      cur = use_lrck ? i2s_lrck : i2s_bck;
      if (cur && !prev) begin
        if (!got1) begin r1 = n; got1 = 1; end
        else r2 = n;
      end
      prev = cur;
    end
    check(name, r2 - r1, exp);
  endtask

  task automatic reset_main();
    reset_n = 0; en = 0; s_valid = 0;
    tick(); tick();
    reset_n = 1;
    tick();
  endtask

  vec_t tv[14];

  initial begin
    int unsigned acc, hi;
    logic rdy;
    n_chk = 0; n_fail = 0; n = 0;
    m_run = 0; m_full = 0; m_t = 0; m_cnt = 0; m_cur = '0; m_prev = '0; m_hold = '0;
    reset_n = 0; en = 0; s_valid = 0; s_left = '0; s_right = '0;
    reset2_n = 0; en2 = 0; valid2 = 0; left2 = '0; right2 = '0;

`ifdef I2S_TX_LEFT_JUSTIFIED_EN
    tv = '{'{0, 0, 1}, '{1, 0, 0}, '{2, 0, 0}, '{14, 0, 0}, '{15, 0, 1}, '{16, 0, 0},
           '{31, 0, 0}, '{32, 1, 0}, '{33, 1, 1}, '{34, 1, 1}, '{46, 1, 1}, '{47, 1, 0},
           '{48, 1, 0}, '{63, 1, 0}};
`else
    tv = '{'{0, 0, 0}, '{1, 0, 1}, '{2, 0, 0}, '{15, 0, 0}, '{16, 0, 1}, '{17, 0, 0},
           '{31, 0, 0}, '{32, 1, 0}, '{33, 1, 0}, '{34, 1, 1}, '{47, 1, 1}, '{48, 1, 0},
           '{49, 1, 0}, '{63, 1, 0}};
`endif

    // Reset state
    tick(); tick();
    check("rst_bck", i2s_bck, 0);
    check("rst_lrck", i2s_lrck, 0);
    check("rst_data", i2s_data, 0);
    check("rst_s_ready", s_ready, 1);
    check("rst_underrun_cnt", underrun_cnt, 0);
    reset_n = 1;
    tick();

    // Pair 8001/7FFE: first frame after start replays the zero pair, next frame carries it
    en = 1; s_valid = 1; s_left = 16'h8001; s_right = 16'h7FFE;
    tick(); n = 0;
    s_valid = 0;
    check("accept_ready_low", s_ready, 0);
    for (int i = 0; i < 14; i++) begin
      run_to(FR + tv[i].b * 2 * BD + 2);
      check($sformatf("vec_lrck_b%0d", tv[i].b), i2s_lrck, tv[i].lrck);
      check($sformatf("vec_data_b%0d", tv[i].b), i2s_data, tv[i].data);
    end
    measure(1'b0, 40, 2 * BD, "bck_period");
    measure(1'b1, 1200, FR, "lrck_period");

    // Starvation after a single pair: underrun count steps once per frame
    reset_main();
    en = 1; s_valid = 1; s_left = 16'h1234; s_right = 16'h5678;
    tick(); n = 0;
    s_valid = 0;
    run_to(1023); check("starve_cnt0", underrun_cnt, 0);
    run_to(1025); check("starve_cnt1", underrun_cnt, 1);
    run_to(1537); check("starve_cnt2", underrun_cnt, 2);
    run_to(1536 + REP_B * 2 * BD + 2); check("starve_repeat_data", i2s_data, 1);
    run_to(2049); check("starve_cnt3", underrun_cnt, 3);

    // Asynchronous reset mid-frame at b=40 with holding full and count nonzero
    s_valid = 1; s_left = 16'hAAAA; s_right = 16'h5555;
    tick(); n++;
    s_valid = 0;
    check("hold_full_ready", s_ready, 0);
    run_to(2048 + 40 * 2 * BD + 5);
    check("pre_rst_bck", i2s_bck, 1);
    check("pre_rst_lrck", i2s_lrck, 1);
    #2 reset_n = 0;
    #1;
    check("async_rst_bck", i2s_bck, 0);
    check("async_rst_lrck", i2s_lrck, 0);
    check("async_rst_data", i2s_data, 0);
    check("async_rst_s_ready", s_ready, 1);
    check("async_rst_cnt", underrun_cnt, 0);
    en = 0;
    tick(); tick();
    reset_n = 1;
    tick();

    // en dropped at b=10: frame completes, then idle; holding survives the idle period
    en = 1;
    tick(); n = 0;
    run_to(80); check("stop_lrck_b10", i2s_lrck, 0);
    en = 0;
    run_to(511);
    check("stop_b63_lrck", i2s_lrck, 1);
    check("stop_b63_bck", i2s_bck, 1);
    run_to(512);
    check("stop_end_bck", i2s_bck, 0);
    check("stop_end_lrck", i2s_lrck, 0);
    check("stop_end_data", i2s_data, 0);
    s_valid = 1; s_left = 16'h0F0F; s_right = 16'hF0F0;
    tick(); n++;
    s_valid = 0;
    run_to(532);
    check("idle_bck", i2s_bck, 0);
    check("idle_hold_ready", s_ready, 0);
    en = 1;
    tick(); n = 0;
    check("restart_lrck", i2s_lrck, 0);
    check("restart_bck", i2s_bck, 0);
    check("restart_loaded_ready", s_ready, 1);
    run_to(4);   check("restart_bck_rise", i2s_bck, 1);
    run_to(255); check("restart_lrck_left", i2s_lrck, 0);
    run_to(256); check("restart_lrck_right", i2s_lrck, 1);

    // Randomized traffic against the reference model
    for (int i = 0; i < 12000; i++) begin
      if (i % 1500 == 0) en = ($urandom_range(0, 3) != 0);
      s_valid = ($urandom_range(0, 99) < 45);
      s_left  = 16'($urandom);
      s_right = 16'($urandom);
      tick();
    end
    en = 0; s_valid = 0;

    // Small-frame instance: reset state, then back-to-back feeding over 100 frames
    tick();
    check("dut2_rst_bck", bck2, 0);
    check("dut2_rst_lrck", lrck2, 0);
    check("dut2_rst_data", data2, 0);
    check("dut2_rst_ready", ready2, 1);
    reset2_n = 1;
    tick();
    en2 = 1; valid2 = 1;
    acc = 0; hi = 0;
    for (int t = 0; t <= 6400; t++) begin
      rdy = ready2;
      left2 = 8'($urandom); right2 = 8'($urandom);
      tick();
      if (rdy) acc++;
      if (t > 0 && ready2) hi++;
    end
    check("b2b_accepts", acc, 100);
    check("b2b_ready_high_cycles", hi, 100);
    check("b2b_underrun", cnt2, 0);

    // Small-frame instance: 300 starved frames saturate the counter
    reset2_n = 0; en2 = 0; valid2 = 0;
    tick();
    reset2_n = 1;
    tick();
    en2 = 1; valid2 = 1; left2 = 8'h12; right2 = 8'h56;
    tick(); n = 0;
    valid2 = 0;
    run_to(129);   check("sat_cnt1", cnt2, 1);
    run_to(193);   check("sat_cnt2", cnt2, 2);
    run_to(257);   check("sat_cnt3", cnt2, 3);
    run_to(16321); check("sat_cnt254", cnt2, 254);
    run_to(16385); check("sat_cnt255", cnt2, 255);
    run_to(19265); check("sat_cnt_hold", cnt2, 255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
